// File: rtl/seq_barrel_shifter.sv
// Iterative barrel shifter: accepts one operand via start/ready, shifts one bit
// position per clock (left/right, logical/rotate), then pulses done_tick.
module seq_barrel_shifter #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [W-1:0]  in,
  input  logic [AW-1:0] amt,
  input  logic          lr,
  input  logic          rot,
  output logic          ready,
  output logic          busy,
  output logic          done_tick,
  output logic [W-1:0]  out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_data,  w_data_nxt;
  logic [AW-1:0] r_cnt,   w_cnt_nxt;
  logic          r_lr,    w_lr_nxt;
  logic          r_rot,   w_rot_nxt;
  logic          r_ready, r_busy, r_done;

  function automatic logic [W-1:0] shift_one(input logic [W-1:0] d,
                                             input logic left,
                                             input logic wrap);
    logic [W-1:0] res;
    if (left) res = {d[W-2:0], (wrap ? d[W-1] : 1'b0)};
    else      res = {(wrap ? d[0] : 1'b0), d[W-1:1]};
    return res;
  endfunction

  // Next-state decode and one-step datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    w_lr_nxt    = r_lr;
    w_rot_nxt   = r_rot;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SHIFT;
          w_data_nxt  = in;
          w_cnt_nxt   = amt;
          w_lr_nxt    = lr;
          w_rot_nxt   = rot;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == {AW{1'b0}}) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_data_nxt = shift_one(r_data, r_lr, r_rot);
          w_cnt_nxt  = r_cnt - AW'(1'b1);
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath and status flags; flags follow the next state so they are registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_data  <= {W{1'b0}};
      r_cnt   <= {AW{1'b0}};
      r_lr    <= 1'b0;
      r_rot   <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lr    <= w_lr_nxt;
      r_rot   <= w_rot_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  assign ready     = r_ready;
  assign busy      = r_busy;
  assign done_tick = r_done;
  assign out       = r_data;

endmodule
